// File: rtl/fp_sqrt_scheduler.sv
// fp_sqrt_scheduler: request FIFO + dispatch FSM in front of a sequential
// float32 square-root unit. One operation in flight; result held in an
// output register until writeback takes it.
module fp_sqrt_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_operand_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             sqrt_valid_o,
  output logic [31:0]      sqrt_operand_o,
  input  logic             sqrt_idle_i,
  input  logic             sqrt_valid_i,
  input  logic [31:0]      sqrt_result_i,
  input  logic [2:0]       sqrt_flags_i,
  input  logic [2:0]       sqrt_round_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_result_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic [2:0]       res_flags_o,
  output logic [2:0]       res_round_o,
  output logic             busy_o
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [31:0]      op_q  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             killed;
  logic [TAG_W-1:0] fly_tag;
  logic             push, dispatch;

  // Ready ignores a same-cycle pop: a full FIFO never accepts.
  assign req_ready_o    = (count != (PW+1)'(DEPTH));
  assign push           = req_valid_i & req_ready_o & ~flush_i;
  assign dispatch       = (count != '0) & sqrt_idle_i & ~flush_i &
                          ((state == IDLE) | ((state == DONE) & res_ready_i));
  assign sqrt_valid_o   = dispatch;
  assign sqrt_operand_o = op_q[rd_ptr];
  assign res_valid_o    = (state == DONE);
  assign busy_o         = (count != '0) | (state != IDLE);

  // Request FIFO: flush wins over push and pop; no bypass to the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        op_q[wr_ptr]  <= req_operand_i;
        tag_q[wr_ptr] <= req_tag_i;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (dispatch) rd_ptr <= rd_ptr + PW'(1);
      case ({push, dispatch})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Dispatch/track/hold FSM. A flush while the unit is busy cannot abort it,
  // so the in-flight op is marked killed and its result discarded on arrival.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      killed       <= 1'b0;
      fly_tag      <= '0;
      res_result_o <= '0;
      res_tag_o    <= '0;
      res_flags_o  <= '0;
      res_round_o  <= '0;
    end else begin
      if (dispatch) begin
        fly_tag <= tag_q[rd_ptr];
        killed  <= 1'b0;
      end
      case (state)
        IDLE: if (dispatch) state <= BUSY;
        BUSY: begin
          if (sqrt_valid_i) begin
            if (killed | flush_i) begin
              state <= IDLE;
            end else begin
              res_result_o <= sqrt_result_i;
              res_tag_o    <= fly_tag;
              res_flags_o  <= sqrt_flags_i;
              res_round_o  <= sqrt_round_i;
              state        <= DONE;
            end
          end else if (flush_i) begin
            killed <= 1'b1;
          end
        end
        DONE: begin
          if (flush_i)          state <= IDLE;
          else if (res_ready_i) state <= dispatch ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
